// File: rtl/l2_port_scheduler.sv
// Round-robin arbiter sharing one L2 port between the L1 icache and dcache.
// A grant locks the captured request until mem_resp; a watchdog flags stalls.
module l2_port_scheduler #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic LG_ICACHE = 1'b0;
    localparam logic LG_DCACHE = 1'b1;

    // A zero timeout leaves the counter pinned at its saturation value of 0.
    localparam int              WDOG_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);

    state_t            state_r;
    logic              last_grant_r;
    logic [WDOG_W-1:0] wdog_r;
    logic              i_req_s;
    logic              d_req_s;
    logic              pick_i_s;
    logic              pick_d_s;

    // Arbitration: on a tie the requester that was not served last wins.
    always_comb begin
        i_req_s  = icache_read;
        d_req_s  = dcache_read | dcache_write;
        pick_i_s = i_req_s & (~d_req_s | (last_grant_r == LG_DCACHE));
        pick_d_s = d_req_s & ~pick_i_s;
    end

    // Response steering is combinational so the L1 sees mem_resp in the same cycle.
    always_comb begin
        icache_resp  = mem_resp & (state_r == GRANT_I);
        dcache_resp  = mem_resp & (state_r == GRANT_D);
        icache_rdata = (state_r == GRANT_I) ? mem_rdata : {LINE_W{1'b0}};
        dcache_rdata = (state_r == GRANT_D) ? mem_rdata : {LINE_W{1'b0}};
    end

    // Grant sequencing, request capture and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= LG_DCACHE;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= {ADDR_W{1'b0}};
            mem_wdata    <= {LINE_W{1'b0}};
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            wdog_r       <= {WDOG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_i_s) begin
                        state_r      <= GRANT_I;
                        last_grant_r <= LG_ICACHE;
                        mem_read     <= 1'b1;
                        mem_write    <= 1'b0;
                        mem_address  <= icache_address;
                        busy         <= 1'b1;
                        wdog_r       <= {WDOG_W{1'b0}};
                    end else if (pick_d_s) begin
                        state_r      <= GRANT_D;
                        last_grant_r <= LG_DCACHE;
                        mem_read     <= ~dcache_write;
                        mem_write    <= dcache_write;
                        mem_address  <= dcache_address;
                        mem_wdata    <= dcache_wdata;
                        busy         <= 1'b1;
                        wdog_r       <= {WDOG_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_resp) begin
                        state_r   <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                    end else if (wdog_r != WDOG_MAX) begin
                        wdog_r <= wdog_r + WDOG_W'(1);
                        if (wdog_r == (WDOG_MAX - WDOG_W'(1))) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for l2_port_scheduler with a short watchdog (TIMEOUT_CYCLES=8).
module tb_l2_port_scheduler;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic              icache_resp;
    logic [LINE_W-1:0] icache_rdata;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic              dcache_resp;
    logic [LINE_W-1:0] dcache_rdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              busy;
    logic              timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    l2_port_scheduler #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .icache_read(icache_read),
        .icache_address(icache_address),
        .icache_resp(icache_resp),
        .icache_rdata(icache_rdata),
        .dcache_read(dcache_read),
        .dcache_write(dcache_write),
        .dcache_address(dcache_address),
        .dcache_wdata(dcache_wdata),
        .dcache_resp(dcache_resp),
        .dcache_rdata(dcache_rdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] line_b;
    logic [LINE_W-1:0] zero_line;

    initial begin
        line_a    = {8{32'hDEAD_BEEF}};
        line_b    = {32{8'hA5}};
        zero_line = {LINE_W{1'b0}};

        rst_n = 1'b0; icache_read = 1'b0; icache_address = 32'h0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = 32'h0;
        dcache_wdata = zero_line; mem_resp = 1'b0; mem_rdata = zero_line;
        tick(); tick();

        // Reset state; mem_resp in IDLE must not leak through.
        mem_resp = 1'b1; mem_rdata = line_a; #1;
        check("rst_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
        check("rst_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
        check("rst_busy", LINE_W'(busy), LINE_W'(1'b0));
        check("rst_timeout", LINE_W'(timeout_err), LINE_W'(1'b0));
        check("rst_addr", LINE_W'(mem_address), LINE_W'(32'h0));
        check("rst_wdata", mem_wdata, zero_line);
        check("rst_iresp", LINE_W'(icache_resp), LINE_W'(1'b0));
        check("rst_dresp", LINE_W'(dcache_resp), LINE_W'(1'b0));
        check("rst_irdata", icache_rdata, zero_line);
        mem_resp = 1'b0; rst_n = 1'b1;
        tick();

        // Single icache read, L2 answers 3 cycles after the grant.
        icache_read = 1'b1; icache_address = 32'h0000_1000;
        tick();
        check("rd_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
        check("rd_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
        check("rd_addr", LINE_W'(mem_address), LINE_W'(32'h0000_1000));
        check("rd_busy", LINE_W'(busy), LINE_W'(1'b1));
        tick(); tick();
        check("rd_iresp_early", LINE_W'(icache_resp), LINE_W'(1'b0));
        mem_resp = 1'b1; mem_rdata = line_a; #1;
        check("rd_iresp", LINE_W'(icache_resp), LINE_W'(1'b1));
        check("rd_irdata", icache_rdata, line_a);
        check("rd_dresp", LINE_W'(dcache_resp), LINE_W'(1'b0));
        check("rd_drdata", dcache_rdata, zero_line);
        tick();
        mem_resp = 1'b0; icache_read = 1'b0; #1;
        check("rd_done_read", LINE_W'(mem_read), LINE_W'(1'b0));
        check("rd_done_busy", LINE_W'(busy), LINE_W'(1'b0));
        check("rd_done_iresp", LINE_W'(icache_resp), LINE_W'(1'b0));

        // Tie right after reset goes to icache first.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        icache_read = 1'b1; icache_address = 32'h0000_5000;
        dcache_write = 1'b1; dcache_address = 32'h0000_4000; dcache_wdata = line_b;
        tick();
        check("tie_first_read", LINE_W'(mem_read), LINE_W'(1'b1));
        check("tie_first_addr", LINE_W'(mem_address), LINE_W'(32'h0000_5000));
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0; icache_read = 1'b0; #1;
        check("tie_bubble_busy", LINE_W'(busy), LINE_W'(1'b0));
        check("tie_bubble_write", LINE_W'(mem_write), LINE_W'(1'b0));
        tick();
        check("tie_second_write", LINE_W'(mem_write), LINE_W'(1'b1));
        check("tie_second_read", LINE_W'(mem_read), LINE_W'(1'b0));
        check("tie_second_addr", LINE_W'(mem_address), LINE_W'(32'h0000_4000));
        check("tie_second_wdata", mem_wdata, line_b);
        mem_resp = 1'b1; mem_rdata = line_a; #1;
        check("tie_dresp", LINE_W'(dcache_resp), LINE_W'(1'b1));
        check("tie_iresp", LINE_W'(icache_resp), LINE_W'(1'b0));
        tick();
        mem_resp = 1'b0; dcache_write = 1'b0;

        // Fairness: both request continuously, last grant was dcache -> I, D, I, D.
        icache_read = 1'b1; icache_address = 32'h0000_6000;
        dcache_read = 1'b1; dcache_address = 32'h0000_7000;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("fair_addr", LINE_W'(mem_address), (t % 2 == 0) ? LINE_W'(32'h0000_6000) : LINE_W'(32'h0000_7000));
            check("fair_read", LINE_W'(mem_read), LINE_W'(1'b1));
            mem_resp = 1'b1;
            tick();
            mem_resp = 1'b0;
            check("fair_bubble", LINE_W'(busy), LINE_W'(1'b0));
        end
        icache_read = 1'b0; dcache_read = 1'b0;
        tick();

        // Lock: L1 inputs change mid-transaction, registered request holds.
        dcache_write = 1'b1; dcache_address = 32'h0000_2000; dcache_wdata = line_b;
        tick();
        check("lock_write", LINE_W'(mem_write), LINE_W'(1'b1));
        dcache_address = 32'h0000_3000; dcache_write = 1'b0;
        tick(); tick();
        check("lock_addr", LINE_W'(mem_address), LINE_W'(32'h0000_2000));
        check("lock_write_held", LINE_W'(mem_write), LINE_W'(1'b1));
        check("lock_read_low", LINE_W'(mem_read), LINE_W'(1'b0));
        mem_resp = 1'b1; #1;
        check("lock_dresp", LINE_W'(dcache_resp), LINE_W'(1'b1));
        tick();
        mem_resp = 1'b0;
        check("lock_done_write", LINE_W'(mem_write), LINE_W'(1'b0));

        // Watchdog: timeout_err rises 8 granted cycles after the grant.
        icache_read = 1'b1; icache_address = 32'h0000_8000;
        tick();
        check("wd_granted", LINE_W'(mem_read), LINE_W'(1'b1));
        for (int k = 1; k < 8; k++) begin
            tick();
            check("wd_not_yet", LINE_W'(timeout_err), LINE_W'(1'b0));
        end
        tick();
        check("wd_set", LINE_W'(timeout_err), LINE_W'(1'b1));
        for (int k = 0; k < 12; k++) tick();
        check("wd_still_read", LINE_W'(mem_read), LINE_W'(1'b1));
        check("wd_still_busy", LINE_W'(busy), LINE_W'(1'b1));
        mem_resp = 1'b1; #1;
        check("wd_iresp", LINE_W'(icache_resp), LINE_W'(1'b1));
        tick();
        mem_resp = 1'b0; icache_read = 1'b0;
        check("wd_idle_busy", LINE_W'(busy), LINE_W'(1'b0));
        tick(); tick();
        check("wd_sticky", LINE_W'(timeout_err), LINE_W'(1'b1));
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("wd_cleared", LINE_W'(timeout_err), LINE_W'(1'b0));

        // Reset mid-transaction drops the request; a late mem_resp is ignored.
        icache_read = 1'b1; icache_address = 32'h0000_9000;
        tick();
        check("mr_granted", LINE_W'(mem_read), LINE_W'(1'b1));
        rst_n = 1'b0; tick(); rst_n = 1'b1; icache_read = 1'b0;
        check("mr_read_low", LINE_W'(mem_read), LINE_W'(1'b0));
        check("mr_busy_low", LINE_W'(busy), LINE_W'(1'b0));
        tick();
        mem_resp = 1'b1; #1;
        check("mr_iresp", LINE_W'(icache_resp), LINE_W'(1'b0));
        check("mr_dresp", LINE_W'(dcache_resp), LINE_W'(1'b0));
        tick();
        mem_resp = 1'b0;
        check("mr_stay_idle", LINE_W'(busy), LINE_W'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l2_port_scheduler.md
Name: l2_port_scheduler

Overview:
- Registered round-robin scheduler that shares the single L2 port between the L1 icache (read-only) and the L1 dcache (read/write).
- Sits between both L1 caches and the L2 cache. Owns grant sequencing, request/address/wdata capture and response steering.
- Adds fairness, a transaction lock until mem_resp, and a stall watchdog.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cache line width
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for mem_resp before timeout_err sets; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- icache_read  in  1  icache line read request, held until icache_resp
- icache_address  in  ADDR_W  icache line address
- icache_resp  out  1  icache transaction done
- icache_rdata  out  LINE_W  icache read line
- dcache_read  in  1  dcache line read request, held until dcache_resp
- dcache_write  in  1  dcache line write request, held until dcache_resp
- dcache_address  in  ADDR_W  dcache line address
- dcache_wdata  in  LINE_W  dcache write line
- dcache_resp  out  1  dcache transaction done
- dcache_rdata  out  LINE_W  dcache read line
- mem_resp  in  1  L2 transaction done
- mem_rdata  in  LINE_W  L2 read line
- mem_read  out  1  L2 read request
- mem_write  out  1  L2 write request
- mem_address  out  ADDR_W  L2 address
- mem_wdata  out  LINE_W  L2 write line
- busy  out  1  a transaction is granted
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE, last_grant=DCACHE
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0
  - busy=0, timeout_err=0, wdog=0
  - icache_resp=0 and dcache_resp=0, because they are gated by state.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - Only icache_read high -> GRANT_I.
  - Only dcache_read|dcache_write high -> GRANT_D.
  - Both requesting -> grant the requester that is not last_grant (round-robin). After reset, icache wins the first tie.
  - No request -> stay in IDLE.
- Grant capture, on the edge entering a GRANT state:
  - Register mem_address and mem_read/mem_write from the winner, and mem_wdata from dcache_wdata (GRANT_D only).
  - Update last_grant and set busy=1.
- Grant latency: a request sampled in IDLE at edge N gives mem_read/mem_write high in cycle N+1.
- GRANT_I: mem_read=1, mem_write=0.
- GRANT_D:
  - dcache_write=1 -> mem_write=1, mem_read=0. Write wins if both dcache_read and dcache_write are high.
  - Otherwise mem_read=1.
- Lock: registered mem outputs hold constant while granted, whatever the L1 inputs do. Deasserting a request mid-transaction does not abort it; the scheduler waits for mem_resp.
- Response steering (combinational):
  - icache_resp = mem_resp & (state==GRANT_I).
  - dcache_resp = mem_resp & (state==GRANT_D).
  - mem_resp in IDLE is ignored.
  - icache_rdata/dcache_rdata = mem_rdata when their state is granted, else 0.
- Completion:
  - mem_resp high in cycle M -> next state IDLE; mem_read, mem_write and busy go to 0 at cycle M+1.
  - Cycle M+1 is a mandatory idle bubble, so a new grant is visible at M+2 at the earliest.
  - A second requester waiting during the transaction is served at M+2. Round-robin guarantees a waiting requester is served within one transaction.
- Watchdog:
  - wdog clears on entry to a GRANT state.
  - It increments each granted cycle without mem_resp and saturates at TIMEOUT_CYCLES.
  - When wdog reaches TIMEOUT_CYCLES (nonzero), timeout_err sets and stays set until reset. The transaction continues normally.
- Reset mid-transaction: rst_n=0 at an edge forces all reset values at that edge, dropping mem_read/mem_write. A mem_resp arriving afterwards is ignored in IDLE.

Test Plan:
- Single read: icache_read=1, icache_address=0x0000_1000, L2 responds 3 cycles after grant -> mem_read=1 and mem_address=0x1000 one cycle after the request. icache_resp pulses 1 cycle with icache_rdata=mem_rdata. mem_read=0 on the next cycle. dcache_resp never asserts.
- Tie after reset: icache_read and dcache_write asserted in the same cycle -> icache is granted first. After its mem_resp and a 1-cycle bubble, mem_write=1 with dcache_address and dcache_wdata=0xA5..A5.
- Fairness: dcache and icache both request continuously for 4 transactions -> grant order I, D, I, D, with exactly one idle cycle between transactions.
- Lock: during GRANT_D, change dcache_address 0x2000->0x3000 and drop dcache_write before mem_resp -> mem_address stays 0x2000 and mem_write stays 1 until mem_resp.
- Watchdog: TIMEOUT_CYCLES=8, mem_resp withheld 20 cycles -> timeout_err rises exactly 8 granted cycles after the grant. After mem_resp the scheduler returns to IDLE and timeout_err stays 1 until rst_n=0.
- Reset mid-transaction: rst_n=0 for 1 edge while in GRANT_I -> mem_read=0 and busy=0 next cycle. A later mem_resp pulse produces no icache_resp or dcache_resp.
